// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the write-back stage of the RV32I core:
//   - datapath / register-address widths (XLEN = 32 only, RADDR_W = 5)
//   - load funct3 encodings (LB, LH, LW, LBU, LHU)
//   - write-back FSM state encoding
//   - small sign/zero-extension helpers used by the load extractor
// Optional feature macro used elsewhere in this slice: WB_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2
    } wb_state_t;

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(XLEN-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(XLEN-16){sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundles every non-clock/reset signal of the write-back stage.
//   master : EX/MEM side + data memory + register-file observer (testbench/core)
//   slave  : the write-back stage itself
// Upstream handshake : in_valid_i / in_ready_o plus instruction fields
// Memory response    : mem_rvalid_i / mem_rdata_i, flush_i cancels a pending load
// Register file      : rf_w_en_o / rf_w_addr_o / rf_w_data_o, busy_o to hazard unit
// With WB_MISALIGN_TRAP_EN defined, misalign_o is added.
// -----------------------------------------------------------------------------
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic               in_valid_i;
    logic               in_ready_o;
    logic               rd_we_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic [XLEN-1:0]    alu_result_i;
    logic               is_load_i;
    logic [2:0]         load_funct3_i;
    logic               flush_i;
    logic               mem_rvalid_i;
    logic [XLEN-1:0]    mem_rdata_i;
    logic               rf_w_en_o;
    logic [RADDR_W-1:0] rf_w_addr_o;
    logic [XLEN-1:0]    rf_w_data_o;
    logic               busy_o;
`ifdef WB_MISALIGN_TRAP_EN
    logic               misalign_o;
`endif

    modport master (
        output in_valid_i, rd_we_i, rd_addr_i, alu_result_i, is_load_i,
               load_funct3_i, flush_i, mem_rvalid_i, mem_rdata_i,
        input  in_ready_o, rf_w_en_o, rf_w_addr_o, rf_w_data_o, busy_o
`ifdef WB_MISALIGN_TRAP_EN
        , input misalign_o
`endif
    );

    modport slave (
        input  in_valid_i, rd_we_i, rd_addr_i, alu_result_i, is_load_i,
               load_funct3_i, flush_i, mem_rvalid_i, mem_rdata_i,
        output in_ready_o, rf_w_en_o, rf_w_addr_o, rf_w_data_o, busy_o
`ifdef WB_MISALIGN_TRAP_EN
        , output misalign_o
`endif
    );

endinterface

// File: rtl/wb_stage_load_extend.sv
// -----------------------------------------------------------------------------
// wb_stage_load_extend
// Combinational load-data extractor.
//   i_funct3     : load type (LB/LH/LW/LBU/LHU, anything else = full word)
//   i_addr       : byte offset of the load within the aligned word
//   i_rdata      : aligned 32-bit word from data memory
//   o_ext_data   : extracted and sign/zero-extended result
//   o_misaligned : (WB_MISALIGN_TRAP_EN only) halfword at odd offset or
//                  word at non-zero offset
// Misaligned halfword/word accesses are rounded down to their natural
// alignment, so o_ext_data is meaningful in both builds.
// -----------------------------------------------------------------------------
module wb_stage_load_extend
    import wb_stage_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_ext_data
`ifdef WB_MISALIGN_TRAP_EN
    ,
    output logic            o_misaligned
`endif
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    // addr[0] is dropped, which rounds an odd halfword address down
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_ext_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_ext_data = ext8(w_byte, 1'b1);
            F3_LBU:  o_ext_data = ext8(w_byte, 1'b0);
            F3_LH:   o_ext_data = ext16(w_half, 1'b1);
            F3_LHU:  o_ext_data = ext16(w_half, 1'b0);
            default: o_ext_data = i_rdata;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    always_comb begin
        o_misaligned = 1'b0;
        case (i_funct3)
            F3_LH, F3_LHU: o_misaligned = i_addr[0];
            F3_LW:         o_misaligned = (i_addr != 2'b00);
            default:       o_misaligned = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage of the 5-stage RV32I core, between the EX/MEM register and
// the register file. Non-loads commit one cycle after the handshake; loads
// wait for the data-memory response and commit the extended data one cycle
// after it. Every rf_* output is registered and pulses for one cycle.
// Ports:
//   clk    : core clock
//   rst_n  : asynchronous, active-low reset
//   bus    : wb_stage_if.slave (handshake, memory response, rf write port,
//            busy_o; misalign_o when WB_MISALIGN_TRAP_EN is defined)
// Optional feature macro: WB_MISALIGN_TRAP_EN -- misaligned loads suppress the
// write and pulse misalign_o instead.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | ready for a new instruction; non-loads commit from here
// WAIT_MEM | load accepted, waiting for mem_rvalid_i (flush may cancel)
// DRAIN    | load was flushed, swallow its response then return to IDLE
// -----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);

    wb_state_t          r_state;
    logic [RADDR_W-1:0] r_rd;
    logic               r_rd_we;
    logic [2:0]         r_funct3;
    logic [1:0]         r_offset;

    logic               r_rf_w_en;
    logic [RADDR_W-1:0] r_rf_w_addr;
    logic [XLEN-1:0]    r_rf_w_data;

    logic [XLEN-1:0]    w_ext_data;
    logic               w_load_commit;

`ifdef WB_MISALIGN_TRAP_EN
    logic               w_misaligned;
    logic               r_misalign;
`endif

    wb_stage_load_extend u_load_extend (
        .i_funct3     (r_funct3),
        .i_addr       (r_offset),
        .i_rdata      (bus.mem_rdata_i),
        .o_ext_data   (w_ext_data)
`ifdef WB_MISALIGN_TRAP_EN
        ,
        .o_misaligned (w_misaligned)
`endif
    );

    // A load to x0 or without rd_we still occupies WAIT_MEM, it just never writes
    assign w_load_commit = r_rd_we && (r_rd != '0);

    assign bus.in_ready_o  = (r_state == IDLE);
    assign bus.busy_o      = (r_state == WAIT_MEM) || (r_state == DRAIN);
    assign bus.rf_w_en_o   = r_rf_w_en;
    assign bus.rf_w_addr_o = r_rf_w_addr;
    assign bus.rf_w_data_o = r_rf_w_data;
`ifdef WB_MISALIGN_TRAP_EN
    assign bus.misalign_o  = r_misalign;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
            r_funct3    <= '0;
            r_offset    <= '0;
            r_rf_w_en   <= 1'b0;
            r_rf_w_addr <= '0;
            r_rf_w_data <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            // The register file forwards on address match without looking at
            // the enable, so address and data must read zero when not writing.
            r_rf_w_en   <= 1'b0;
            r_rf_w_addr <= '0;
            r_rf_w_data <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        if (bus.is_load_i) begin
                            r_rd     <= bus.rd_addr_i;
                            r_rd_we  <= bus.rd_we_i;
                            r_funct3 <= bus.load_funct3_i;
                            r_offset <= bus.alu_result_i[1:0];
                            r_state  <= WAIT_MEM;
                        end else if (bus.rd_we_i && (bus.rd_addr_i != '0)) begin
                            r_rf_w_en   <= 1'b1;
                            r_rf_w_addr <= bus.rd_addr_i;
                            r_rf_w_data <= bus.alu_result_i;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid_i) begin
                        // Response arriving with flush is consumed and dropped
                        r_state <= IDLE;
                        if (!bus.flush_i) begin
`ifdef WB_MISALIGN_TRAP_EN
                            if (w_misaligned) begin
                                r_misalign <= 1'b1;
                            end else if (w_load_commit) begin
                                r_rf_w_en   <= 1'b1;
                                r_rf_w_addr <= r_rd;
                                r_rf_w_data <= w_ext_data;
                            end
`else
                            if (w_load_commit) begin
                                r_rf_w_en   <= 1'b1;
                                r_rf_w_addr <= r_rd;
                                r_rf_w_data <= w_ext_data;
                            end
`endif
                        end
                    end else if (bus.flush_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.mem_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int n_cmp;
    int n_err;
    bit mon_en;

    wb_stage_if bus();

    wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        exp_en;
        logic [31:0] exp_data;
        logic        mis;
    } vec_t;

    typedef struct {
        int unsigned due;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int unsigned due, input logic en, input logic [4:0] addr,
                        input logic [31:0] data, input logic mis);
        exp_t e;
        e.due  = due;
        e.en   = en;
        e.addr = addr;
        e.data = data;
        e.mis  = mis;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.in_valid_i    = 1'b0;
        bus.rd_we_i       = 1'b0;
        bus.rd_addr_i     = '0;
        bus.alu_result_i  = '0;
        bus.is_load_i     = 1'b0;
        bus.load_funct3_i = '0;
        bus.flush_i       = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rdata_i   = $urandom;
    endtask

    task automatic drive_add(input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.in_valid_i   = 1'b1;
        bus.is_load_i    = 1'b0;
        bus.rd_we_i      = we;
        bus.rd_addr_i    = rd;
        bus.alu_result_i = d;
        if (we && rd != 5'd0) push(cyc + 1, 1'b1, rd, d, 1'b0);
    endtask

    task automatic drive_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a);
        bus.in_valid_i    = 1'b1;
        bus.is_load_i     = 1'b1;
        bus.rd_we_i       = 1'b1;
        bus.rd_addr_i     = rd;
        bus.alu_result_i  = a;
        bus.load_funct3_i = f3;
    endtask

    // Scoreboard monitor: at the due cycle the write must match, otherwise the
    // write port (and misalign_o) must be entirely zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("w_en",   32'(bus.rf_w_en_o),   32'(e.en));
                chk("w_addr", 32'(bus.rf_w_addr_o), 32'(e.addr));
                chk("w_data", bus.rf_w_data_o,      e.data);
`ifdef WB_MISALIGN_TRAP_EN
                chk("misalign", 32'(bus.misalign_o), 32'(e.mis));
`endif
            end else begin
                chk("idle_w_en",   32'(bus.rf_w_en_o),   32'd0);
                chk("idle_w_addr", 32'(bus.rf_w_addr_o), 32'd0);
                chk("idle_w_data", bus.rf_w_data_o,      32'd0);
`ifdef WB_MISALIGN_TRAP_EN
                chk("idle_misalign", 32'(bus.misalign_o), 32'd0);
`endif
            end
        end
    end

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        tick();
        chk($sformatf("v%0d_ready_pre", i), 32'(bus.in_ready_o), 32'd1);
        bus.in_valid_i    = 1'b1;
        bus.is_load_i     = v.is_load;
        bus.load_funct3_i = v.f3;
        bus.rd_we_i       = v.rd_we;
        bus.rd_addr_i     = v.rd;
        bus.alu_result_i  = v.alu;
        if (!v.is_load && v.exp_en) push(cyc + 1, 1'b1, v.rd, v.exp_data, 1'b0);
        tick();
        quiet();
        if (v.is_load) begin
            chk($sformatf("v%0d_ready_wait", i), 32'(bus.in_ready_o), 32'd0);
            chk($sformatf("v%0d_busy_wait", i),  32'(bus.busy_o),     32'd1);
            tick();
            chk($sformatf("v%0d_busy_wait2", i), 32'(bus.busy_o), 32'd1);
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = v.rdata;
`ifdef WB_MISALIGN_TRAP_EN
            if (v.mis) push(cyc + 1, 1'b0, 5'd0, 32'd0, 1'b1);
            else if (v.exp_en) push(cyc + 1, 1'b1, v.rd, v.exp_data, 1'b0);
`else
            if (v.exp_en) push(cyc + 1, 1'b1, v.rd, v.exp_data, 1'b0);
`endif
            tick();
            quiet();
        end
        chk($sformatf("v%0d_ready_post", i), 32'(bus.in_ready_o), 32'd1);
        chk($sformatf("v%0d_busy_post", i),  32'(bus.busy_o),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b1;
        quiet();

        //          load  f3      we    rd     alu            rdata          en    exp_data       mis
        vecs[0]  = '{1'b0, 3'b000, 1'b1, 5'd5,  32'h1234_5678, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
        vecs[1]  = '{1'b1, F3_LB,  1'b1, 5'd3,  32'h0000_1003, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b1, F3_LBU, 1'b1, 5'd3,  32'h0000_1003, 32'h80FF_0000, 1'b1, 32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b1, F3_LH,  1'b1, 5'd10, 32'h0000_2002, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001, 1'b0};
        vecs[4]  = '{1'b1, F3_LHU, 1'b1, 5'd10, 32'h0000_2002, 32'h8001_7FFF, 1'b1, 32'h0000_8001, 1'b0};
        vecs[5]  = '{1'b0, 3'b000, 1'b1, 5'd0,  32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 3'b000, 1'b0, 5'd7,  32'h0000_55AA, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, F3_LW,  1'b1, 5'd9,  32'h0000_0040, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b1, F3_LB,  1'b1, 5'd11, 32'h0000_0000, 32'h0000_007F, 1'b1, 32'h0000_007F, 1'b0};
        vecs[9]  = '{1'b1, F3_LB,  1'b1, 5'd12, 32'h0000_0001, 32'h0000_8000, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[10] = '{1'b1, F3_LBU, 1'b1, 5'd13, 32'h0000_0002, 32'h00AB_0000, 1'b1, 32'h0000_00AB, 1'b0};
        vecs[11] = '{1'b1, F3_LH,  1'b1, 5'd14, 32'h0000_0001, 32'h1234_ABCD, 1'b1, 32'hFFFF_ABCD, 1'b1};
        vecs[12] = '{1'b1, F3_LW,  1'b1, 5'd15, 32'h0000_0002, 32'h1122_3344, 1'b1, 32'h1122_3344, 1'b1};
        vecs[13] = '{1'b1, F3_LW,  1'b1, 5'd0,  32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
        vecs[14] = '{1'b1, 3'b011, 1'b1, 5'd16, 32'h0000_0001, 32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF, 1'b0};
        vecs[15] = '{1'b1, F3_LHU, 1'b1, 5'd17, 32'h0000_0000, 32'h0000_F00F, 1'b1, 32'h0000_F00F, 1'b0};
        vecs[16] = '{1'b1, F3_LH,  1'b1, 5'd18, 32'h0000_0000, 32'h0000_7FFF, 1'b1, 32'h0000_7FFF, 1'b0};
        vecs[17] = '{1'b1, F3_LW,  1'b0, 5'd19, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0,         1'b0};
        vecs[18] = '{1'b0, 3'b000, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0};

        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        #10;
        chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_busy",  32'(bus.busy_o),     32'd0);
        #11 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) apply_vec(i);

        // Back-to-back non-loads: one commit per cycle
        tick();
        drive_add(1'b1, 5'd1, 32'hAAAA_0001);
        tick();
        chk("b2b_ready1", 32'(bus.in_ready_o), 32'd1);
        drive_add(1'b1, 5'd2, 32'hAAAA_0002);
        tick();
        chk("b2b_ready2", 32'(bus.in_ready_o), 32'd1);
        drive_add(1'b1, 5'd3, 32'hAAAA_0003);
        tick();
        quiet();

        // Flush one cycle after the load, response three cycles later
        tick();
        drive_load(F3_LW, 5'd4, 32'h0000_0000);
        tick();
        quiet();
        bus.flush_i = 1'b1;
        chk("fl_busy_wait", 32'(bus.busy_o), 32'd1);
        tick();
        quiet();
        chk("fl_busy_d1",  32'(bus.busy_o),     32'd1);
        chk("fl_ready_d1", 32'(bus.in_ready_o), 32'd0);
        bus.flush_i = 1'b1;
        tick();
        quiet();
        chk("fl_busy_d2", 32'(bus.busy_o), 32'd1);
        tick();
        chk("fl_busy_d3",  32'(bus.busy_o),     32'd1);
        chk("fl_ready_d3", 32'(bus.in_ready_o), 32'd0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h7777_7777;
        tick();
        quiet();
        chk("fl_ready_after", 32'(bus.in_ready_o), 32'd1);
        chk("fl_busy_after",  32'(bus.busy_o),     32'd0);
        drive_add(1'b1, 5'd6, 32'h0BAD_F00D);
        tick();
        quiet();

        // Flush and response in the same cycle: discarded, straight to IDLE
        tick();
        drive_load(F3_LW, 5'd8, 32'h0000_0000);
        tick();
        quiet();
        bus.flush_i      = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h5555_5555;
        tick();
        quiet();
        chk("flrv_ready", 32'(bus.in_ready_o), 32'd1);
        chk("flrv_busy",  32'(bus.busy_o),     32'd0);

        // Response and flush while IDLE are ignored; the ADD still commits
        bus.mem_rvalid_i = 1'b1;
        bus.flush_i      = 1'b1;
        drive_add(1'b1, 5'd20, 32'h1357_9BDF);
        tick();
        quiet();
        chk("idle_rv_ready", 32'(bus.in_ready_o), 32'd1);

        // Reset in WAIT_MEM: pending load is dropped
        tick();
        drive_load(F3_LB, 5'd21, 32'h0000_0000);
        tick();
        quiet();
        chk("rstw_busy_pre", 32'(bus.busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("rstw_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rstw_busy",  32'(bus.busy_o),     32'd0);
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0042;
        tick();
        quiet();
        chk("rstw_ready_post", 32'(bus.in_ready_o), 32'd1);

        // Reset in DRAIN
        tick();
        drive_load(F3_LW, 5'd22, 32'h0000_0000);
        tick();
        quiet();
        bus.flush_i = 1'b1;
        tick();
        quiet();
        chk("rstd_busy_pre", 32'(bus.busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("rstd_ready", 32'(bus.in_ready_o), 32'd1);
        drive_add(1'b1, 5'd23, 32'h2468_ACE0);
        tick();
        quiet();

        tick();
        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage RV32I core. Sits between the EX/MEM pipeline register and the register file.
- Accepts one retiring instruction per handshake. For loads, waits for the data-memory response and sign/zero-extends the returned word.
- Drives the register-file write port (enable/address/data) for exactly one cycle per committed write.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- RADDR_W, 5, register address width (32 architectural registers).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid_i  in  1  EX/MEM presents an instruction
- in_ready_o  out  1  stage can accept (handshake completes when valid && ready)
- rd_we_i  in  1  instruction writes rd
- rd_addr_i  in  RADDR_W  destination register
- alu_result_i  in  XLEN  result for non-loads; byte address for loads
- is_load_i  in  1  instruction is a load
- load_funct3_i  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101
- flush_i  in  1  cancel the pending load (trap/redirect)
- mem_rvalid_i  in  1  data-memory read response valid
- mem_rdata_i  in  XLEN  aligned 32-bit word from data memory
- rf_w_en_o  out  1  register-file write enable
- rf_w_addr_o  out  RADDR_W  register-file write address
- rf_w_data_o  out  XLEN  register-file write data
- busy_o  out  1  high in WAIT_MEM or DRAIN (feeds the hazard unit)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, all capture registers 0.
  - rf_w_en_o=0, rf_w_addr_o=0, rf_w_data_o=0, busy_o=0.
  - in_ready_o=1 combinationally once state is IDLE.
- The register file forwards on address match without qualifying enable. Therefore rf_w_addr_o and rf_w_data_o are forced to 0 in every cycle where rf_w_en_o=0.
- All rf_* outputs are registered and pulse for one cycle per commit.
- A write to rd=0, or with rd_we_i=0, never asserts rf_w_en_o. A load to x0 still waits for its response.
- FSM states: IDLE, WAIT_MEM, DRAIN.
- IDLE:
  - in_ready_o=1.
  - On handshake with is_load_i=0: next cycle rf_w_en_o=(rd_we_i && rd_addr_i!=0), data=alu_result_i. Latency 1; throughput 1 per cycle.
  - On handshake with is_load_i=1: capture rd, funct3, alu_result_i[1:0]; go to WAIT_MEM. No write this cycle.
  - mem_rvalid_i in IDLE is ignored.
- WAIT_MEM:
  - in_ready_o=0, busy_o=1.
  - mem_rvalid_i=1 and flush_i=0: extend the data; next cycle rf_w_en_o asserts with the load result; state -> IDLE.
  - flush_i=1 and mem_rvalid_i=0: state -> DRAIN, no write.
  - flush_i=1 and mem_rvalid_i=1 in the same cycle: response consumed and discarded; state -> IDLE, no write.
- DRAIN:
  - in_ready_o=0, busy_o=1.
  - Wait for mem_rvalid_i, discard the data, then IDLE. flush_i is ignored.
- flush_i in IDLE has no effect. The upstream stage is responsible for not presenting flushed instructions.
- Load extraction (offset = captured addr[1:0]):
  - Byte = mem_rdata_i[8*offset +: 8].
  - Halfword = mem_rdata_i[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and all other funct3 codes use the full word.
- Misaligned accesses (LH/LHU with addr[0]=1, LW with addr[1:0]!=0):
  - Without the optional feature, the address is rounded down (addr[0] and addr[1:0] ignored respectively).
- Reset asserted mid-WAIT_MEM or mid-DRAIN: immediate return to IDLE; no write is issued for the pending load.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_o (1 bit).
  - On the response of a misaligned load: rf_w_en_o stays 0 and misalign_o pulses high for one cycle, in the cycle the write would have occurred.
  - Flushed loads never raise misalign_o.
- Undefined:
  - Port absent; rounding-down behaviour as above.

Decomposition:
- Shared header (existing defines file):
  - Load funct3 constants: LB, LH, LW, LBU, LHU.
  - FSM state encodings: IDLE=2'd0, WAIT_MEM=2'd1, DRAIN=2'd2.
  - Register-address and data bus width macros.
- One natural combinational sub-module, load_extend: inputs funct3, addr[1:0], rdata; outputs ext_data and misaligned.

Test Plan:
1. ADD result: handshake with rd=5, data=0x1234_5678, is_load=0 -> next cycle w_en=1, addr=5, data=0x1234_5678. The cycle after: w_en=0, addr=0, data=0.
2. LB: addr[1:0]=2'b11, rdata=0x80FF_0000, rd=3 -> in_ready_o=0 until rvalid. Cycle after rvalid: w_en=1, data=0xFFFF_FF80. Repeat as LBU -> data=0x0000_0080.
3. LH: addr[1:0]=2'b10, rdata=0x8001_7FFF -> data=0xFFFF_8001. LHU, same inputs -> data=0x0000_8001.
4. Flush: load issued, flush_i one cycle later, rvalid 3 cycles after that -> DRAIN for 3 cycles, no w_en, busy_o=1 throughout. Next ADD is accepted the cycle after rvalid.
5. x0 and enable gating: rd=0 ADD with data=0xDEAD_BEEF -> w_en, addr and data all stay 0. rd_we_i=0, rd=7 -> no write.
6. Reset asserted during WAIT_MEM, rvalid arrives after deassertion -> no write, state IDLE, in_ready_o=1. With WB_MISALIGN_TRAP_EN defined: LW at addr 0x...2 -> misalign_o pulses once, w_en=0.
